// File: rtl/riscv_wb_pkg.sv
// Shared constants for the RV32I writeback stage.
// Load funct3 encodings and named writeback source indices.
// No ports; imported by load_formatter and wb_stage.
package riscv_wb_pkg;

  // Load funct3 encodings; 3, 6 and 7 are illegal for loads.
  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5
  } ld_funct3_e;

  // Writeback source indices into the flattened source bus.
  localparam int unsigned WB_SRC_MEM = 0;
  localparam int unsigned WB_SRC_ALU = 1;
  localparam int unsigned WB_SRC_PC4 = 2;
  localparam int unsigned WB_SRC_IMM = 3;

endpackage

// File: rtl/load_formatter.sv
// Load formatter: extracts the addressed byte/halfword from a memory word and extends it.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: word_i memory word, funct3_i load type, offset_i byte offset; data_o result, err_o misaligned/illegal.
module load_formatter
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane extraction is independent of funct3; the case below only picks extension.
  assign byte_v = word_i[{offset_i, 3'b000} +: 8];
  assign half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        if (offset_i[0]) err_o = 1'b1;
        else             data_o = {{(XLEN-16){half_v[15]}}, half_v};
      end
      F3_LHU: begin
        if (offset_i[0]) err_o = 1'b1;
        else             data_o = {{(XLEN-16){1'b0}}, half_v};
      end
      F3_LW: begin
        if (offset_i != 2'd0) err_o = 1'b1;
        else                  data_o = word_i;
      end
      // Errored loads leave data_o at zero so nothing stale reaches the regfile.
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: N-source select, load formatting, MEM/WB register, retire counter.
// Latency: 1 cycle from accept to RF_* outputs. Backpressure: IN_READY = !OUT_VALID || RF_READY; held outputs stay stable.
// Ports: IN_VALID/IN_READY/FLUSH handshake, WB_SEL/DATA_SRC/LD_FUNCT3/ADDR_LSB/RD_* payload, RF_READY/RF_* write port, LD_ERR, RETIRE_CNT.
module wb_stage #(
  parameter  int XLEN    = 32,
  parameter  int NUM_SRC = 4,
  parameter  int RA_W    = 5,
  parameter  int CNT_W   = 32,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    FLUSH,
  input  logic [SEL_W-1:0]        WB_SEL,
  input  logic [NUM_SRC*XLEN-1:0] DATA_SRC,
  input  logic [2:0]              LD_FUNCT3,
  input  logic [1:0]              ADDR_LSB,
  input  logic [RA_W-1:0]         RD_ADDR_IN,
  input  logic                    RD_WE_IN,
  input  logic                    RF_READY,
  output logic                    OUT_VALID,
  output logic                    RF_WE,
  output logic [RA_W-1:0]         RF_ADDR,
  output logic [XLEN-1:0]         RF_DATA,
  output logic                    LD_ERR,
  output logic [CNT_W-1:0]        RETIRE_CNT
);
  import riscv_wb_pkg::*;

  localparam int SEL_N = 2 ** SEL_W;

  // Source table padded to the full index range so out-of-range selects read zero.
  logic [XLEN-1:0] src_arr [SEL_N];
  for (genvar k = 0; k < SEL_N; k++) begin : g_src
    if (k < NUM_SRC) begin : g_real
      assign src_arr[k] = DATA_SRC[k*XLEN +: XLEN];
    end else begin : g_pad
      assign src_arr[k] = '0;
    end
  end

  logic [XLEN-1:0] fmt_data;
  logic            fmt_err;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .word_i   (DATA_SRC[XLEN-1:0]),
    .funct3_i (LD_FUNCT3),
    .offset_i (ADDR_LSB),
    .data_o   (fmt_data),
    .err_o    (fmt_err)
  );

  logic            is_mem;
  logic [XLEN-1:0] sel_data;
  logic            sel_err;

  assign is_mem   = (WB_SEL == SEL_W'(WB_SRC_MEM));
  assign sel_data = is_mem ? fmt_data : src_arr[WB_SEL];
  assign sel_err  = is_mem & fmt_err;

  logic            out_valid_q, out_valid_d;
  logic            rd_we_q,     rd_we_d;
  logic [RA_W-1:0] rf_addr_q,   rf_addr_d;
  logic [XLEN-1:0] rf_data_q,   rf_data_d;
  logic            ld_err_q,    ld_err_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic accept;
  logic xfer;

  assign IN_READY = !out_valid_q || RF_READY;
  assign accept   = IN_VALID && IN_READY && !FLUSH;
  // A flush kills the held instruction, so it never counts as a transfer.
  assign xfer     = out_valid_q && RF_READY && !FLUSH;

  always_comb begin
    out_valid_d = out_valid_q;
    rd_we_d     = rd_we_q;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    ld_err_d    = ld_err_q;
    cnt_d       = cnt_q;
    if (xfer && !ld_err_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (FLUSH) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      // Covers simultaneous drain and accept: no bubble.
      out_valid_d = 1'b1;
      rd_we_d     = RD_WE_IN;
      rf_addr_d   = RD_ADDR_IN;
      rf_data_d   = sel_data;
      ld_err_d    = sel_err;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      rd_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      ld_err_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rd_we_q     <= rd_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      ld_err_q    <= ld_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign OUT_VALID  = out_valid_q;
  assign RF_ADDR    = rf_addr_q;
  assign RF_DATA    = rf_data_q;
  assign LD_ERR     = ld_err_q;
  assign RETIRE_CNT = cnt_q;
  // x0 is hardwired zero, so a write to it is never strobed.
  assign RF_WE      = out_valid_q && rd_we_q && (rf_addr_q != '0) && !ld_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vectors, scoreboard queue filled at accept, monitor pops at each transfer.
// Runs with CNT_W=4 so the retire counter wraps within a short run.
module tb_wb_stage;

  logic         CLK;
  logic         RST_N;
  logic         IN_VALID;
  logic         IN_READY;
  logic         FLUSH;
  logic [1:0]   WB_SEL;
  logic [127:0] DATA_SRC;
  logic [2:0]   LD_FUNCT3;
  logic [1:0]   ADDR_LSB;
  logic [4:0]   RD_ADDR_IN;
  logic         RD_WE_IN;
  logic         RF_READY;
  logic         OUT_VALID;
  logic         RF_WE;
  logic [4:0]   RF_ADDR;
  logic [31:0]  RF_DATA;
  logic         LD_ERR;
  logic [3:0]   RETIRE_CNT;

  wb_stage #(.XLEN(32), .NUM_SRC(4), .RA_W(5), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .FLUSH(FLUSH),
    .WB_SEL(WB_SEL), .DATA_SRC(DATA_SRC), .LD_FUNCT3(LD_FUNCT3), .ADDR_LSB(ADDR_LSB),
    .RD_ADDR_IN(RD_ADDR_IN), .RD_WE_IN(RD_WE_IN), .RF_READY(RF_READY),
    .OUT_VALID(OUT_VALID), .RF_WE(RF_WE), .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
    .LD_ERR(LD_ERR), .RETIRE_CNT(RETIRE_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] exp_cnt;
  int         checks = 0;
  int         errors = 0;
  int         st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every transfer; a flushed instruction is dropped unchecked.
  always @(negedge CLK) begin
    if (RST_N && OUT_VALID) begin
      if (FLUSH) begin
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else if (RF_READY) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got addr %h data %h, expected nothing", RF_ADDR, RF_DATA);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("mon_addr", {27'd0, RF_ADDR}, {27'd0, e.addr});
          chk("mon_data", RF_DATA, e.data);
          chk("mon_we", {31'd0, RF_WE}, {31'd0, e.we});
          chk("mon_err", {31'd0, LD_ERR}, {31'd0, e.err});
          chk("mon_cnt", {28'd0, RETIRE_CNT}, {28'd0, exp_cnt});
          if (!e.err) exp_cnt = exp_cnt + 4'd1;
        end
      end
    end
  end

  task automatic setup(input logic [1:0] sel, input logic [31:0] word, input logic [2:0] f3,
                       input logic [1:0] off, input logic [4:0] rd, input logic we);
    DATA_SRC = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    DATA_SRC[sel*32 +: 32] = word;
    WB_SEL = sel; LD_FUNCT3 = f3; ADDR_LSB = off; RD_ADDR_IN = rd; RD_WE_IN = we;
    IN_VALID = 1'b1;
  endtask

  // Called just after a rising edge; returns after the accepting edge.
  task automatic send(input logic [1:0] sel, input logic [31:0] word, input logic [2:0] f3,
                      input logic [1:0] off, input logic [4:0] rd, input logic we,
                      input logic [31:0] exp_d, input logic exp_we, input logic exp_err,
                      output int stalls);
    bit done;
    exp_t e;
    done = 0;
    stalls = 0;
    setup(sel, word, f3, off, rd, we);
    while (!done && stalls < 50) begin
      @(negedge CLK);
      if (IN_READY && !FLUSH) begin
        e.addr = rd; e.data = exp_d; e.we = exp_we; e.err = exp_err;
        sb_q.push_back(e);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected accept for rd %0d", rd);
    end else begin
      chk("lat_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("lat_addr", {27'd0, RF_ADDR}, {27'd0, rd});
      chk("lat_data", RF_DATA, exp_d);
      chk("lat_we", {31'd0, RF_WE}, {31'd0, exp_we});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
    chk({tag, "_we"}, {31'd0, RF_WE}, 32'd0);
    chk({tag, "_addr"}, {27'd0, RF_ADDR}, 32'd0);
    chk({tag, "_data"}, RF_DATA, 32'd0);
    chk({tag, "_err"}, {31'd0, LD_ERR}, 32'd0);
    chk({tag, "_cnt"}, {28'd0, RETIRE_CNT}, 32'd0);
    chk({tag, "_inready"}, {31'd0, IN_READY}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_cnt = 4'd0;
    RST_N = 1'b0; IN_VALID = 1'b0; FLUSH = 1'b0; WB_SEL = 2'd0; DATA_SRC = '0;
    LD_FUNCT3 = 3'd0; ADDR_LSB = 2'd0; RD_ADDR_IN = 5'd0; RD_WE_IN = 1'b0; RF_READY = 1'b1;
    #3;
    chk_all_zero("reset");
    #9 RST_N = 1'b1;
    @(posedge CLK); #1;

    // Load formatting on word 0x8070_F0FF.
    send(2'd0, 32'h8070_F0FF, 3'd0, 2'd1, 5'd5,  1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0, st);
    send(2'd0, 32'h8070_F0FF, 3'd4, 2'd3, 5'd6,  1'b1, 32'h0000_0080, 1'b1, 1'b0, st);
    send(2'd0, 32'h8070_F0FF, 3'd0, 2'd2, 5'd7,  1'b1, 32'h0000_0070, 1'b1, 1'b0, st);
    send(2'd0, 32'h8070_F0FF, 3'd1, 2'd2, 5'd8,  1'b1, 32'hFFFF_8070, 1'b1, 1'b0, st);
    send(2'd0, 32'h8070_F0FF, 3'd5, 2'd0, 5'd9,  1'b1, 32'h0000_F0FF, 1'b1, 1'b0, st);
    send(2'd0, 32'h8070_F0FF, 3'd2, 2'd0, 5'd10, 1'b1, 32'h8070_F0FF, 1'b1, 1'b0, st);
    // Misaligned and illegal loads: error, no strobe, zero data, not counted.
    send(2'd0, 32'h8070_F0FF, 3'd2, 2'd2, 5'd11, 1'b1, 32'h0000_0000, 1'b0, 1'b1, st);
    send(2'd0, 32'h8070_F0FF, 3'd1, 2'd1, 5'd12, 1'b1, 32'h0000_0000, 1'b0, 1'b1, st);
    send(2'd0, 32'h8070_F0FF, 3'd3, 2'd0, 5'd13, 1'b1, 32'h0000_0000, 1'b0, 1'b1, st);
    idle(2);
    chk("cnt_after_loads", {28'd0, RETIRE_CNT}, 32'd6);

    // Backpressure: hold three cycles with a second instruction waiting.
    RF_READY = 1'b0;
    send(2'd1, 32'h1234_5678, 3'd0, 2'd0, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 1'b0, st);
    setup(2'd3, 32'hCAFE_F00D, 3'd0, 2'd0, 5'd4, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      chk("hold_inready", {31'd0, IN_READY}, 32'd0);
      chk("hold_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("hold_addr", {27'd0, RF_ADDR}, 32'd3);
      chk("hold_data", RF_DATA, 32'h1234_5678);
      chk("hold_we", {31'd0, RF_WE}, 32'd1);
      @(posedge CLK); #1;
    end
    RF_READY = 1'b1;
    send(2'd3, 32'hCAFE_F00D, 3'd0, 2'd0, 5'd4, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, st);
    chk("release_stalls", st, 32'd0);
    idle(2);
    chk("cnt_after_bp", {28'd0, RETIRE_CNT}, 32'd8);

    // Write to x0: counted, never strobed.
    send(2'd1, 32'h5555_5555, 3'd0, 2'd0, 5'd0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, st);
    idle(2);
    chk("cnt_after_x0", {28'd0, RETIRE_CNT}, 32'd9);

    // Flush a held instruction while a new one is offered.
    RF_READY = 1'b0;
    send(2'd2, 32'h0000_0400, 3'd0, 2'd0, 5'd14, 1'b1, 32'h0000_0400, 1'b1, 1'b0, st);
    setup(2'd1, 32'h7777_7777, 3'd0, 2'd0, 5'd15, 1'b1);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk("flush_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("flush_we", {31'd0, RF_WE}, 32'd0);
    RF_READY = 1'b1;
    idle(2);
    chk("flush_no_accept", {31'd0, OUT_VALID}, 32'd0);
    chk("cnt_after_flush", {28'd0, RETIRE_CNT}, 32'd9);

    // Eight back-to-back PC+4 writebacks: no stalls, counter wraps past 15.
    for (int i = 0; i < 8; i++) begin
      send(2'd2, 32'h0000_1000 + 32'(4*i), 3'd0, 2'd0, 5'(16 + i), 1'b1,
           32'h0000_1000 + 32'(4*i), 1'b1, 1'b0, st);
      chk("b2b_stalls", st, 32'd0);
    end
    idle(2);
    chk("cnt_after_b2b", {28'd0, RETIRE_CNT}, 32'd1);

    // Drive the counter to 15, then one more transfer wraps it to 0.
    for (int i = 0; i < 20 && exp_cnt != 4'd15; i++) begin
      send(2'd1, 32'(i), 3'd0, 2'd0, 5'd1, 1'b1, 32'(i), 1'b1, 1'b0, st);
      idle(1);
    end
    chk("cnt_at_15", {28'd0, RETIRE_CNT}, 32'd15);
    send(2'd3, 32'h0000_00AB, 3'd0, 2'd0, 5'd2, 1'b0, 32'h0000_00AB, 1'b0, 1'b0, st);
    idle(1);
    chk("cnt_wrap", {28'd0, RETIRE_CNT}, 32'd0);

    // Asynchronous reset while an instruction is held.
    RF_READY = 1'b0;
    send(2'd1, 32'hA5A5_A5A5, 3'd0, 2'd0, 5'd20, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, st);
    #2 RST_N = 1'b0;
    #1;
    chk_all_zero("arst");
    sb_q.delete();
    exp_cnt = 4'd0;
    @(negedge CLK); #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    RF_READY = 1'b1;
    send(2'd1, 32'h0BAD_CAFE, 3'd0, 2'd0, 5'd21, 1'b1, 32'h0BAD_CAFE, 1'b1, 1'b0, st);
    idle(2);
    chk("cnt_after_arst", {28'd0, RETIRE_CNT}, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
